// File: rtl/mem_sched_if.sv
// mem_sched_if -- bundles the two requester ports, the memory-clear handshake
// and the memory-side bus of mem_sched.
//   slave  : scheduler side (mem_sched). It takes requests and clr_start and
//            drives the grants, read returns and error pulses. It also drives
//            the memory address, enables and write data, and takes mem_rdata.
//   master : environment side (requesters plus the attached memory).
interface mem_sched_if;
   logic        req0, req1;
   logic        we0, we1;
   logic [15:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1;
   logic        rvalid0, rvalid1;
   logic [31:0] rdata;
   logic        err0, err1;
   logic        clr_start, clr_busy, clr_done;
   logic [15:0] mem_addr;
   logic        mem_rd_en, mem_wr_en;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_start, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, err0, err1, clr_busy, clr_done,
             mem_addr, mem_rd_en, mem_wr_en, mem_wdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_start, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, err0, err1, clr_busy, clr_done,
             mem_addr, mem_rd_en, mem_wr_en, mem_wdata
   );
endinterface

// File: rtl/mem_sched.sv
// mem_sched -- two-requester round-robin scheduler in front of a single-port
// word memory, with a built-in sweep that clears the whole memory.
//   clk, rst : single clock; synchronous active-high reset
//   bus      : mem_sched_if.slave
//              req/we/addr/wdata 0,1 -> gnt 0,1 (combinational; the access
//              completes in the grant cycle)
//              rvalid 0,1 / rdata    -> read return, one cycle after grant
//              err 0,1               -> pulses for out-of-range (0 or > MEM_SIZE)
//              clr_start/busy/done   -> memory-clear handshake
//              mem_*                 -> memory with registered rdata
// MEM_SIZE : number of 32-bit words; valid addresses are 1..MEM_SIZE.
module mem_sched #(
   parameter int unsigned MEM_SIZE = 512
) (
   input  logic        clk,
   input  logic        rst,
   mem_sched_if.slave  bus
);

   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [16:0] LAST_ADDR = 17'(MEM_SIZE);

   state_t      state, state_nxt;
   logic        last1;        // 1: requester 1 holds the most recent grant
   logic [16:0] clr_cnt;      // one spare bit, so a full 16-bit sweep cannot wrap
   logic        g0, g1;
   logic        sel_we;
   logic [15:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        in_range;
   logic        rd_en, wr_en;
   logic [15:0] m_addr;
   logic [31:0] m_wdata;
   logic        rvalid0_q, rvalid1_q, err0_q, err1_q, oor_rd_q, clr_done_q;

   always_comb begin
      state_nxt = state;
      g0        = 1'b0;
      g1        = 1'b0;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;

      case (state)
         IDLE: begin
            if (bus.clr_start) begin
               state_nxt = CLEAR;
            end else if (bus.req0 && bus.req1) begin
               g0 = last1;
               g1 = ~last1;
            end else begin
               g0 = bus.req0;
               g1 = bus.req1;
            end
         end
         CLEAR: begin
            if (clr_cnt == LAST_ADDR) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      sel_we    = g1 ? bus.we1    : bus.we0;
      sel_addr  = g1 ? bus.addr1  : bus.addr0;
      sel_wdata = g1 ? bus.wdata1 : bus.wdata0;
      in_range  = (sel_addr != 16'd0) && ({1'b0, sel_addr} <= LAST_ADDR);

      if (g0 || g1) begin
         m_addr  = sel_addr;
         m_wdata = sel_wdata;
         wr_en   = sel_we & in_range;
         rd_en   = ~sel_we & in_range;
      end

      if (state == CLEAR) begin
         m_addr = clr_cnt[15:0];
         wr_en  = 1'b1;
      end

      // Reset masks every side effect, including a clear write in progress.
      if (rst) begin
         g0    = 1'b0;
         g1    = 1'b0;
         rd_en = 1'b0;
         wr_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last1      <= 1'b1;
         clr_cnt    <= 17'd1;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         err0_q     <= 1'b0;
         err1_q     <= 1'b0;
         oor_rd_q   <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (g0 || g1) last1 <= g1;
         rvalid0_q  <= g0 & ~sel_we;
         rvalid1_q  <= g1 & ~sel_we;
         err0_q     <= g0 & ~in_range;
         err1_q     <= g1 & ~in_range;
         oor_rd_q   <= (g0 | g1) & ~sel_we & ~in_range;
         clr_done_q <= (state == CLEAR) && (clr_cnt == LAST_ADDR);
         if (state == CLEAR && clr_cnt != LAST_ADDR) clr_cnt <= clr_cnt + 17'd1;
         else                                        clr_cnt <= 17'd1;
      end
   end

   assign bus.gnt0      = g0;
   assign bus.gnt1      = g1;
   assign bus.mem_addr  = m_addr;
   assign bus.mem_rd_en = rd_en;
   assign bus.mem_wr_en = wr_en;
   assign bus.mem_wdata = m_wdata;
   assign bus.rvalid0   = rvalid0_q;
   assign bus.rvalid1   = rvalid1_q;
   assign bus.err0      = err0_q;
   assign bus.err1      = err1_q;
   assign bus.rdata     = oor_rd_q ? '0 : bus.mem_rdata;
   assign bus.clr_busy  = (state == CLEAR);
   assign bus.clr_done  = clr_done_q;

endmodule

// File: tb/tb_mem_sched.sv
// tb_mem_sched -- self-checking bench for mem_sched (MEM_SIZE = 512).
// The bench provides the attached memory (registered rdata, 0 when not
// reading). A reference model checks grants, memory-bus activity and read
// returns. The model is an array of expected word contents plus the identity
// of the last winner.
module tb_mem_sched;
   localparam int unsigned N = 512;

   logic clk;
   logic rst;
   mem_sched_if bus ();

   mem_sched #(.MEM_SIZE(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // attached memory
   logic [31:0] mem_arr [0:1023];
   always @(posedge clk) begin
      if (bus.mem_wr_en) mem_arr[bus.mem_addr[9:0]] <= bus.mem_wdata;
      bus.mem_rdata <= bus.mem_rd_en ? mem_arr[bus.mem_addr[9:0]] : 32'd0;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model
   logic [31:0] ref_mem [0:1023];
   int          last_win;
   logic        p_rv0, p_rv1, p_er0, p_er1;
   logic [31:0] p_rd;

   task automatic model_reset();
      last_win = 1;
      p_rv0 = 1'b0; p_rv1 = 1'b0; p_er0 = 1'b0; p_er1 = 1'b0;
      p_rd  = '0;
   endtask

   task automatic idle_inputs();
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
      bus.clr_start = 1'b0;
   endtask

   // One IDLE-state cycle; entered and left at posedge+1.
   task automatic cyc(input logic r0, input logic w0, input logic [15:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [15:0] a1, input logic [31:0] d1);
      int          g;
      logic        w, inr;
      logic [15:0] a;
      logic [31:0] d;
      bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
      bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
      bus.clr_start = 1'b0;
      @(negedge clk);
      chk("rvalid0", 32'(bus.rvalid0), 32'(p_rv0));
      chk("rvalid1", 32'(bus.rvalid1), 32'(p_rv1));
      chk("err0", 32'(bus.err0), 32'(p_er0));
      chk("err1", 32'(bus.err1), 32'(p_er1));
      if (p_rv0 || p_rv1) chk("rdata", bus.rdata, p_rd);
      if (r0 && r1)  g = 1 - last_win;
      else if (r0)   g = 0;
      else if (r1)   g = 1;
      else           g = -1;
      chk("gnt0", 32'(bus.gnt0), 32'(g == 0));
      chk("gnt1", 32'(bus.gnt1), 32'(g == 1));
      p_rv0 = 1'b0; p_rv1 = 1'b0; p_er0 = 1'b0; p_er1 = 1'b0;
      if (g >= 0) begin
         w   = (g == 1) ? w1 : w0;
         a   = (g == 1) ? a1 : a0;
         d   = (g == 1) ? d1 : d0;
         inr = (a != 16'd0) && (int'(a) <= int'(N));
         chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(inr && w));
         chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(inr && !w));
         if (inr) chk("mem_addr", 32'(bus.mem_addr), 32'(a));
         if (inr && w) chk("mem_wdata", bus.mem_wdata, d);
         if (!w) begin
            p_rd = inr ? ref_mem[a[9:0]] : 32'd0;
            if (g == 0) p_rv0 = 1'b1; else p_rv1 = 1'b1;
         end
         if (!inr) begin
            if (g == 0) p_er0 = 1'b1; else p_er1 = 1'b1;
         end
         if (inr && w) ref_mem[a[9:0]] = d;
         last_win = g;
      end else begin
         chk("mem_wr_en_idle", 32'(bus.mem_wr_en), 32'd0);
         chk("mem_rd_en_idle", 32'(bus.mem_rd_en), 32'd0);
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'd3; bus.wdata0 = 32'h1111_2222;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'd4;
      @(negedge clk);
      chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
      chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
      chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
      chk("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle_inputs();
      chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
      chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
      chk("rst_err0", 32'(bus.err0), 32'd0);
      chk("rst_err1", 32'(bus.err1), 32'd0);
      chk("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
      chk("rst_clr_done", 32'(bus.clr_done), 32'd0);
      model_reset();
   endtask

   function automatic logic [15:0] rnd_addr();
      case ($urandom_range(0, 9))
         0:       return 16'd0;
         1:       return 16'd513;
         2:       return 16'($urandom);
         default: return 16'($urandom_range(1, N));
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      idle_inputs();
      model_reset();
      @(posedge clk); #1;
      do_reset();

      // fill the whole memory
      for (int i = 1; i <= int'(N); i++) cyc(1'b1, 1'b1, 16'(i), $urandom, 1'b0, 1'b0, 16'd0, 32'd0);

      // both requesters held after reset: grants alternate starting with 0
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'd10, 32'd0, 1'b1, 1'b0, 16'd11, 32'd0);

      // write via req0, read back via req1
      cyc(1'b1, 1'b1, 16'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 16'd0, 32'd0);
      cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 1'b0, 16'd5, 32'd0);
      chk("rb_rvalid1", 32'(bus.rvalid1), 32'd1);
      chk("rb_rdata", bus.rdata, 32'hDEAD_BEEF);

      // out-of-range reads
      cyc(1'b1, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0);
      cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 1'b0, 16'd513, 32'd0);
      cyc(1'b1, 1'b1, 16'hFFFF, 32'h5A5A_5A5A, 1'b0, 1'b0, 16'd0, 32'd0);
      cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0);

      // full clear: clr_start beats a pending request
      bus.clr_start = 1'b1;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'd4;
      @(negedge clk);
      chk("cs_gnt0", 32'(bus.gnt0), 32'd0);
      chk("cs_gnt1", 32'(bus.gnt1), 32'd0);
      chk("cs_rd_en", 32'(bus.mem_rd_en), 32'd0);
      chk("cs_wr_en", 32'(bus.mem_wr_en), 32'd0);
      chk("cs_busy", 32'(bus.clr_busy), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      for (int k = 1; k <= int'(N); k++) begin
         if (k == 10) begin bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'd7; end
         bus.clr_start = (k == 20);
         @(negedge clk);
         chk("clr_busy", 32'(bus.clr_busy), 32'd1);
         chk("clr_addr", 32'(bus.mem_addr), 32'(k));
         chk("clr_wr_en", 32'(bus.mem_wr_en), 32'd1);
         chk("clr_rd_en", 32'(bus.mem_rd_en), 32'd0);
         chk("clr_wdata", bus.mem_wdata, 32'd0);
         chk("clr_gnt0", 32'(bus.gnt0), 32'd0);
         chk("clr_gnt1", 32'(bus.gnt1), 32'd0);
         chk("clr_done_early", 32'(bus.clr_done), 32'd0);
         @(posedge clk); #1;
      end
      bus.clr_start = 1'b0;
      chk("clr_done", 32'(bus.clr_done), 32'd1);
      chk("clr_busy_fall", 32'(bus.clr_busy), 32'd0);
      for (int i = 1; i <= int'(N); i++) ref_mem[i] = 32'd0;
      cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 1'b0, 16'd7, 32'd0);
      chk("clr_done_pulse", 32'(bus.clr_done), 32'd0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 16'($urandom_range(1, N)), 32'd0, 1'b0, 1'b0, 16'd0, 32'd0);

      // reset in the middle of a clear
      cyc(1'b1, 1'b1, 16'd200, 32'h1234_5678, 1'b0, 1'b0, 16'd0, 32'd0);
      cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b1, 1'b1, 16'd50, 32'h5555_AAAA);
      cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0);
      bus.clr_start = 1'b1;
      @(posedge clk); #1;
      bus.clr_start = 1'b0;
      for (int k = 1; k < 100; k++) begin
         @(negedge clk);
         chk("rc_addr", 32'(bus.mem_addr), 32'(k));
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("rc_wr_en", 32'(bus.mem_wr_en), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rc_busy", 32'(bus.clr_busy), 32'd0);
      chk("rc_done", 32'(bus.clr_done), 32'd0);
      for (int i = 1; i < 100; i++) ref_mem[i] = 32'd0;
      model_reset();
      cyc(1'b1, 1'b0, 16'd200, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0);
      chk("rc_done_after", 32'(bus.clr_done), 32'd0);
      cyc(1'b1, 1'b0, 16'd50, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0);
      cyc(1'b0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 16'd0, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 512, number of 32-bit words in the attached mem (valid addresses 1..MEM_SIZE).
REQ-002 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0/req1  input  1  per-requester access request (0 = loader, 1 = solver).
REQ-005 SHALL have ports we0/we1  input  1  write when 1, read when 0, qualified by reqN.
REQ-006 SHALL have ports addr0/addr1  input  16, and wdata0/wdata1  input  32: requester address and write data.
REQ-007 SHALL have ports gnt0/gnt1  output  1  combinational grant; the access completes in the cycle gntN=1.
REQ-008 SHALL have ports rvalid0/rvalid1  output  1, and rdata  output  32: read return, shared data bus.
REQ-009 SHALL have ports err0/err1  output  1  one-cycle pulse for an out-of-range access.
REQ-010 SHALL have ports clr_start  input  1, clr_busy  output  1, clr_done  output  1: memory-clear handshake.
REQ-011 SHALL have ports mem_addr  output  16, mem_rd_en  output  1, mem_wr_en  output  1, mem_wdata  output  32, mem_rdata  input  32: interface to mem, whose rdata is registered and reads 0 when rd_en=0.

Function
REQ-012 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on clr_start=1; CLEAR->IDLE after the write to address MEM_SIZE.
REQ-013 In IDLE, at most one gnt SHALL assert per cycle, and only to a requester with reqN=1; with no clr_start, a lone requester SHALL be granted in the same cycle.
REQ-014 On simultaneous req0 and req1, the grant SHALL go to the requester not granted most recently (round-robin); the last-grant pointer SHALL update only on a grant.
REQ-015 A granted access SHALL drive mem_addr=addrN, mem_wr_en=weN, mem_rd_en=~weN and mem_wdata=wdataN combinationally in the grant cycle; all mem enables SHALL be 0 when nothing is granted.
REQ-016 rvalidN SHALL assert exactly one cycle after a granted in-range read by requester N; rdata SHALL equal mem_rdata in that cycle.
REQ-017 An address of 0 or greater than MEM_SIZE SHALL still be granted, with both mem enables forced to 0; errN SHALL pulse in the cycle after the grant.
REQ-018 An out-of-range read SHALL also pulse rvalidN with rdata=0.
REQ-019 clr_start in IDLE SHALL take priority over requests: no gnt in that cycle, with clr_busy=1 from the next cycle.
REQ-020 In CLEAR, the block SHALL write 32'd0 to addresses 1..MEM_SIZE in ascending order, one per cycle (mem_wr_en=1, mem_rd_en=0), taking exactly MEM_SIZE cycles.
REQ-021 In CLEAR, gnt0/gnt1 SHALL be 0; requesters hold their requests, which are served in IDLE afterwards.
REQ-022 clr_done SHALL pulse for one cycle in the cycle after the final clear write; clr_busy SHALL fall in that same cycle.
REQ-023 clr_start received while in CLEAR SHALL be ignored (no restart, no extension).
REQ-024 The clear address counter SHALL be at least 16 bits wide and SHALL NOT wrap within a sweep.

Reset
REQ-025 On rst=1 at posedge, the FSM SHALL go to IDLE and the last-grant pointer SHALL be set so requester 0 wins the first tie.
REQ-026 On rst=1 at posedge, rvalid0/1, err0/1, clr_busy and clr_done SHALL be 0 and the clear counter SHALL be 1.
REQ-027 While rst=1, gnt0/1 and all mem enables SHALL be 0.
REQ-028 Reset during CLEAR SHALL abort the sweep without a clr_done pulse; already-cleared words remain cleared.

Verification
REQ-029 Bench: write 0xDEADBEEF to addr 5 via req0, then read addr 5 via req1 -> gnt1 in the same cycle, rvalid1=1 with rdata=0xDEADBEEF one cycle later.
REQ-030 Bench: req0 and req1 held high for 4 cycles after reset -> grants 0,1,0,1.
REQ-031 Bench: read addr 0 and addr 513 (MEM_SIZE=512) -> mem enables 0, err and rvalid pulse, rdata=0.
REQ-032 Bench: fill addrs 1..512, clr_start -> clr_busy high for 512 cycles, ascending zero writes, one clr_done pulse; subsequent reads return 0.
REQ-033 Bench: req1 asserted at cycle 10 of a clear -> no gnt1 until the FSM returns to IDLE, then gnt1 in the first IDLE cycle.
REQ-034 Bench: rst at cycle 100 of a clear -> no clr_done, IDLE next cycle, addr 200 retains its old value and addr 50 reads 0.
